// File: rtl/next_pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package next_pc_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    TRAP  = 2'd2
  } pc_state_t;

  function automatic logic word_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_unit.sv
// PC sequencer: advances by 4 or redirects to ALURes one cycle after a taken branch,
// then squashes FLUSH_CYCLES wrong-path fetches; Stall holds PC, a taken redirect overrides it.
module next_pc_unit
  import next_pc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                NextPCSrc,
  input  logic                BrValid,
  input  logic [XLEN-1:0]     ALURes,
  input  logic                Stall,
  output logic [XLEN-1:0]     PC,
  output logic [XLEN-1:0]     PCInc,
  output logic                InstValid,
  output logic                Flush,
  output logic                MisalignTrap
);

  localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_CYCLES);

  if (FLUSH_CYCLES > 7 || RESET_PC[1:0] != 2'b00) begin : g_bad_param
    $error("next_pc_unit: FLUSH_CYCLES must be <= 7 and RESET_PC word-aligned");
  end

  pc_state_t       r_state;
  logic [2:0]      r_cnt;
  logic [XLEN-1:0] r_pc;
  logic            r_flush;
  logic            r_trap;

  pc_state_t       w_state_nxt;
  logic [2:0]      w_cnt_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_pc_inc;
  logic            w_flush_nxt;
  logic            w_trap_nxt;
  logic            w_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FLUSH;
      r_cnt   <= 3'd1;
      r_pc    <= RESET_PC;
      r_flush <= 1'b0;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pc    <= w_pc_nxt;
      r_flush <= w_flush_nxt;
      r_trap  <= w_trap_nxt;
    end
  end

  always_comb begin
    w_pc_inc    = r_pc + XLEN'(INST_BYTES);
    w_taken     = BrValid && NextPCSrc;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_nxt    = r_pc;
    w_flush_nxt = 1'b0;
    w_trap_nxt  = r_trap;
    case (r_state)
      RUN: begin
        if (w_taken) begin
          // Misaligned targets still kill the wrong path, but PC never takes the bad address.
          w_flush_nxt = 1'b1;
          if (word_aligned(ALURes[1:0])) begin
            w_pc_nxt = ALURes;
            if (FLUSH_CYCLES != 0) begin
              w_state_nxt = FLUSH;
              w_cnt_nxt   = FLUSH_CNT;
            end
          end else begin
            w_trap_nxt  = 1'b1;
            w_state_nxt = TRAP;
          end
        end else if (!Stall) begin
          w_pc_nxt = w_pc_inc;
        end
      end
      FLUSH: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) begin
          w_state_nxt = RUN;
        end
      end
      TRAP: begin
        w_trap_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = FLUSH;
        w_cnt_nxt   = 3'd1;
      end
    endcase
  end

  assign PC           = r_pc;
  assign PCInc        = w_pc_inc;
  assign InstValid    = (r_state == RUN);
  assign Flush        = r_flush;
  assign MisalignTrap = r_trap;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench: default instance (RESET_PC=0) plus a wrap instance (RESET_PC=FFFF_FFF8).
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        nps0, brv0, stall0;
  logic [31:0] alu0;
  logic [31:0] pc0, pcinc0;
  logic        iv0, fl0, tr0;
  logic        nps1, brv1, stall1;
  logic [31:0] alu1;
  logic [31:0] pc1, pcinc1;
  logic        iv1, fl1, tr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  next_pc_unit dut0 (
    .clk(clk), .rst(rst), .NextPCSrc(nps0), .BrValid(brv0), .ALURes(alu0), .Stall(stall0),
    .PC(pc0), .PCInc(pcinc0), .InstValid(iv0), .Flush(fl0), .MisalignTrap(tr0)
  );

  next_pc_unit #(.RESET_PC(32'hFFFF_FFF8), .FLUSH_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .NextPCSrc(nps1), .BrValid(brv1), .ALURes(alu1), .Stall(stall1),
    .PC(pc1), .PCInc(pcinc1), .InstValid(iv1), .Flush(fl1), .MisalignTrap(tr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    nps0 = 0; brv0 = 0; stall0 = 0; alu0 = 32'h0;
    nps1 = 0; brv1 = 0; stall1 = 0; alu1 = 32'h0;
  endtask

  // Leaves both instances in their first post-reset (FLUSH) cycle with rst low.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    checks++; if (pc0 !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc0, 32'h0); end
    checks++; if (pcinc0 !== 32'h4) begin errors++; $display("FAIL reset_pcinc: got %h want %h", pcinc0, 32'h4); end
    checks++; if (iv0 !== 1'b0) begin errors++; $display("FAIL reset_instvalid: got %b want 0", iv0); end
    checks++; if (fl0 !== 1'b0 || tr0 !== 1'b0) begin errors++; $display("FAIL reset_flush_trap: got %b%b want 00", fl0, tr0); end
    checks++; if (pc1 !== 32'hFFFF_FFF8 || pcinc1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_wrapinst: got %h/%h want fffffff8/fffffffc", pc1, pcinc1); end
    rst = 0;
    checks++; if (iv0 !== 1'b0 || pc0 !== 32'h0) begin errors++; $display("FAIL post_reset_bubble: got iv=%b pc=%h want iv=0 pc=0", iv0, pc0); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pc0 !== exp_pc || iv0 !== 1'b1) begin errors++; $display("FAIL free_run[%0d]: got pc=%h iv=%b want pc=%h iv=1", i, pc0, iv0, exp_pc); end
      checks++; if (pcinc0 !== exp_pc + 32'h4) begin errors++; $display("FAIL free_run_pcinc[%0d]: got %h want %h", i, pcinc0, exp_pc + 32'h4); end
      exp_pc = exp_pc + 32'h4;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(); tick(); tick();
    checks++; if (pc0 !== 32'h8 || iv0 !== 1'b1) begin errors++; $display("FAIL redir_pre: got pc=%h iv=%b want pc=00000008 iv=1", pc0, iv0); end
    brv0 = 1; nps0 = 1; alu0 = 32'h40;
    tick();
    brv0 = 0; nps0 = 0; alu0 = 32'h0;
    checks++; if (pc0 !== 32'h40 || fl0 !== 1'b1 || iv0 !== 1'b0) begin errors++; $display("FAIL redir_edge: got pc=%h fl=%b iv=%b want pc=00000040 fl=1 iv=0", pc0, fl0, iv0); end
    tick();
    checks++; if (pc0 !== 32'h40 || fl0 !== 1'b0 || iv0 !== 1'b0) begin errors++; $display("FAIL redir_bubble2: got pc=%h fl=%b iv=%b want pc=00000040 fl=0 iv=0", pc0, fl0, iv0); end
    tick();
    checks++; if (pc0 !== 32'h40 || iv0 !== 1'b1) begin errors++; $display("FAIL redir_target_valid: got pc=%h iv=%b want pc=00000040 iv=1", pc0, iv0); end
    tick();
    checks++; if (pc0 !== 32'h44 || iv0 !== 1'b1 || pcinc0 !== 32'h48) begin errors++; $display("FAIL redir_advance: got pc=%h iv=%b inc=%h want 00000044 1 00000048", pc0, iv0, pcinc0); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (pc0 !== 32'h10) begin errors++; $display("FAIL stall_pre: got %h want 00000010", pc0); end
    stall0 = 1;
    tick();
    checks++; if (pc0 !== 32'h10 || iv0 !== 1'b1) begin errors++; $display("FAIL stall_hold1: got pc=%h iv=%b want 00000010 1", pc0, iv0); end
    tick();
    checks++; if (pc0 !== 32'h10) begin errors++; $display("FAIL stall_hold2: got %h want 00000010", pc0); end
    brv0 = 1; nps0 = 1; alu0 = 32'h80;
    tick();
    clear_inputs();
    checks++; if (pc0 !== 32'h80 || fl0 !== 1'b1) begin errors++; $display("FAIL stall_redirect_wins: got pc=%h fl=%b want 00000080 1", pc0, fl0); end
  endtask

  task automatic test_misalign();
    do_reset();
    tick(); tick();
    brv0 = 1; nps0 = 1; alu0 = 32'h42;
    tick();
    clear_inputs();
    checks++; if (tr0 !== 1'b1 || fl0 !== 1'b1 || pc0 !== 32'h4 || iv0 !== 1'b0) begin errors++; $display("FAIL misalign_edge: got tr=%b fl=%b pc=%h iv=%b want 1 1 00000004 0", tr0, fl0, pc0, iv0); end
    for (int i = 0; i < 10; i++) begin
      brv0 = (i == 3); nps0 = (i == 3); alu0 = 32'h100;
      tick();
      checks++; if (pc0 !== 32'h4 || iv0 !== 1'b0 || tr0 !== 1'b1 || fl0 !== 1'b0) begin errors++; $display("FAIL misalign_frozen[%0d]: got pc=%h iv=%b tr=%b fl=%b want 00000004 0 1 0", i, pc0, iv0, tr0, fl0); end
    end
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    checks++; if (pc0 !== 32'h0 || tr0 !== 1'b0 || iv0 !== 1'b0) begin errors++; $display("FAIL misalign_reset: got pc=%h tr=%b iv=%b want 00000000 0 0", pc0, tr0, iv0); end
    tick();
    checks++; if (pc0 !== 32'h0 || iv0 !== 1'b1) begin errors++; $display("FAIL misalign_recover: got pc=%h iv=%b want 00000000 1", pc0, iv0); end
  endtask

  task automatic test_wrap();
    do_reset();
    brv1 = 1; nps1 = 1; alu1 = 32'h100;
    tick();
    clear_inputs();
    checks++; if (pc1 !== 32'hFFFF_FFF8 || iv1 !== 1'b1 || fl1 !== 1'b0) begin errors++; $display("FAIL wrap_ignore_in_flush: got pc=%h iv=%b fl=%b want fffffff8 1 0", pc1, iv1, fl1); end
    tick();
    checks++; if (pc1 !== 32'hFFFF_FFFC || pcinc1 !== 32'h0) begin errors++; $display("FAIL wrap_top: got pc=%h inc=%h want fffffffc 00000000", pc1, pcinc1); end
    tick();
    checks++; if (pc1 !== 32'h0 || tr1 !== 1'b0 || iv1 !== 1'b1) begin errors++; $display("FAIL wrap_zero: got pc=%h tr=%b iv=%b want 00000000 0 1", pc1, tr1, iv1); end
    brv1 = 0; nps1 = 1; alu1 = 32'h300;
    tick();
    clear_inputs();
    checks++; if (pc1 !== 32'h4 || fl1 !== 1'b0) begin errors++; $display("FAIL brvalid_gate: got pc=%h fl=%b want 00000004 0", pc1, fl1); end
  endtask

  task automatic test_back_to_back();
    brv1 = 1; nps1 = 1; alu1 = 32'h200;
    tick();
    alu1 = 32'h100;
    checks++; if (pc1 !== 32'h200 || fl1 !== 1'b1) begin errors++; $display("FAIL b2b_first: got pc=%h fl=%b want 00000200 1", pc1, fl1); end
    tick();
    clear_inputs();
    checks++; if (pc1 !== 32'h200 || fl1 !== 1'b0 || iv1 !== 1'b0) begin errors++; $display("FAIL b2b_ignored: got pc=%h fl=%b iv=%b want 00000200 0 0", pc1, fl1, iv1); end
    tick();
    checks++; if (pc1 !== 32'h200 || iv1 !== 1'b1) begin errors++; $display("FAIL b2b_valid: got pc=%h iv=%b want 00000200 1", pc1, iv1); end
    tick();
    checks++; if (pc1 !== 32'h204) begin errors++; $display("FAIL b2b_advance: got %h want 00000204", pc1); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_redirect();
    test_stall();
    test_misalign();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
